// File: rtl/mux2_rr_arbiter_pkg.sv
// mux2_rr_arbiter_pkg: state encoding and width helper shared by the arbiter slice
package mux2_rr_arbiter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: requester/consumer bundle around the shared 2:1 datapath
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic [1:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [1:0]       gnt;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CNT_W-1:0] owner_cnt;
  modport master(output req, din0, din1, input gnt, sel, dout, dout_valid, owner_cnt);
  modport slave(input req, din0, din1, output gnt, sel, dout, dout_valid, owner_cnt);
endinterface

// File: rtl/mux2_reg_dp.sv
// mux2_reg_dp: registered 2:1 select with load enable
module mux2_reg_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= '0;
    else if (i_load) o_q <= i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a registered 2:1 datapath with burst limit
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              cp,
  input logic              rst,
  mux2_rr_arbiter_if.slave bus
);
  localparam int CNT_W = clog2(MAX_BURST) + 1;
  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, w_last_nxt, r_dv;
  logic             w_own, w_sel, w_xfer, w_other, w_burst_end;
  assign w_own       = r_state == OWN1;
  assign w_sel       = r_state == OWN1;
  assign w_xfer      = (r_state == OWN0 && bus.req[0]) || (r_state == OWN1 && bus.req[1]);
  assign w_other     = bus.req[~w_own];
  assign w_burst_end = r_cnt == CNT_W'(MAX_BURST - 1);
  // the burst counter wraps at the limit; it only forces a handover when contended
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_last_nxt  = r_last;
    if (r_state == IDLE)
      w_state_nxt = bus.req == 2'b11 ? (r_last ? OWN0 : OWN1) :
                    bus.req[0] ? OWN0 : bus.req[1] ? OWN1 : IDLE;
    else if (w_xfer) begin
      w_cnt_nxt = w_burst_end ? '0 : r_cnt + 1'b1;
      if (w_burst_end && w_other) begin
        w_state_nxt = w_own ? OWN0 : OWN1;
        w_last_nxt  = w_own;
      end
    end else begin
      w_last_nxt  = w_own;
      w_state_nxt = w_other ? (w_own ? OWN0 : OWN1) : IDLE;
    end
  end
  always_ff @(posedge cp or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_dv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_dv    <= w_xfer;
    end
  mux2_reg_dp #(.WIDTH(WIDTH)) u_dp (
    .clk   (cp),
    .rst   (rst),
    .i_load(w_xfer),
    .i_sel (w_sel),
    .i_d0  (bus.din0),
    .i_d1  (bus.din1),
    .o_q   (bus.dout)
  );
  assign bus.gnt        = {r_state == OWN1, r_state == OWN0};
  assign bus.sel        = w_sel;
  assign bus.dout_valid = r_dv;
  assign bus.owner_cnt  = r_cnt;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed scoreboard bench for burst-4 and ping-pong builds
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;
  logic cp = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  bit prev_xfer = 1'b0;
  logic [7:0] sb[$];
  mux2_rr_arbiter_if #(.WIDTH(8), .CNT_W(clog2(4) + 1)) ifa ();
  mux2_rr_arbiter_if #(.WIDTH(8), .CNT_W(clog2(1) + 1)) ifb ();
  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_a (.cp(cp), .rst(rst), .bus(ifa));
  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_b (.cp(cp), .rst(rst), .bus(ifb));
  always #5 cp = ~cp;
  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit b, input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] eg, input int ec);
    bit x;
    if (b) begin
      ifb.req = rq; ifb.din0 = d0; ifb.din1 = d1;
    end else begin
      ifa.req = rq; ifa.din0 = d0; ifa.din1 = d1;
    end
    @(negedge cp);
    chk("gnt", b ? ifb.gnt : ifa.gnt, eg);
    chk("sel", b ? ifb.sel : ifa.sel, eg[1]);
    chk("owner_cnt", b ? int'(ifb.owner_cnt) : int'(ifa.owner_cnt), ec);
    chk("dout_valid", b ? ifb.dout_valid : ifa.dout_valid, prev_xfer);
    x = |(eg & rq);
    if (x) sb.push_back(eg[1] ? d1 : d0);
    prev_xfer = x;
    @(posedge cp);
    #1;
  endtask
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge cp);
      if (ifa.dout_valid || ifb.dout_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL dout: unexpected word %0h at %0t", ifa.dout_valid ? ifa.dout : ifb.dout, $time);
        end else begin
          e = sb.pop_front();
          chk("dout", ifa.dout_valid ? ifa.dout : ifb.dout, e);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end
  initial begin
    int g1[13] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    int c1[13] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int gp[6]  = '{0, 1, 2, 1, 2, 1};
    ifa.req = 2'b00; ifa.din0 = '0; ifa.din1 = '0;
    ifb.req = 2'b00; ifb.din0 = '0; ifb.din1 = '0;
    repeat (2) @(posedge cp);
    @(negedge cp);
    chk("rst_gnt", ifa.gnt, 0);
    chk("rst_sel", ifa.sel, 0);
    chk("rst_dout", ifa.dout, 0);
    chk("rst_dv", ifa.dout_valid, 0);
    chk("rst_cnt", ifa.owner_cnt, 0);
    @(posedge cp);
    #1 rst = 1'b0;
    // contention: bursts of four alternate, requester 0 first
    for (int i = 0; i < 13; i++)
      cyc(0, 2'b11, 8'(8'hA0 + i), 8'(8'hB0 + i), 2'(g1[i]), c1[i]);
    // uncontended requester 0: counter wraps, no gaps
    cyc(0, 2'b01, 8'h00, 8'h00, 2'b10, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 2'b01, 8'(i), 8'hEE, 2'b01, i % 4);
    // owner drops mid-burst while the other requests
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b01, 2);
    cyc(0, 2'b01, 8'h50, 8'h00, 2'b00, 0);
    cyc(0, 2'b01, 8'h51, 8'h00, 2'b01, 0);
    cyc(0, 2'b10, 8'h52, 8'hB0, 2'b01, 1);
    cyc(0, 2'b10, 8'h53, 8'hB1, 2'b10, 0);
    cyc(0, 2'b10, 8'h54, 8'hB2, 2'b10, 1);
    cyc(0, 2'b10, 8'h55, 8'hB3, 2'b10, 2);
    // both drop in OWN1: idle, dout holds, requester 0 wins next
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b10, 3);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    chk("dout_hold", ifa.dout, 8'hB3);
    cyc(0, 2'b11, 8'hC0, 8'hD0, 2'b00, 0);
    for (int i = 1; i < 5; i++)
      cyc(0, 2'b11, 8'(8'hC0 + i), 8'(8'hD0 + i), 2'b01, i - 1);
    cyc(0, 2'b11, 8'hC5, 8'hD5, 2'b10, 0);
    // asynchronous reset in the middle of the OWN1 burst
    ifa.din0 = 8'hC6;
    ifa.din1 = 8'hD6;
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_gnt", ifa.gnt, 0);
    chk("arst_sel", ifa.sel, 0);
    chk("arst_dout", ifa.dout, 0);
    chk("arst_dv", ifa.dout_valid, 0);
    chk("arst_cnt", ifa.owner_cnt, 0);
    @(posedge cp);
    #1 rst = 1'b0;
    prev_xfer = 1'b0;
    cyc(0, 2'b11, 8'hE0, 8'hF0, 2'b00, 0);
    cyc(0, 2'b11, 8'hE1, 8'hF1, 2'b01, 0);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b01, 1);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    // MAX_BURST=1 build: strict ping-pong
    for (int i = 0; i < 6; i++)
      cyc(1, 2'b11, 8'(8'h10 + i), 8'(8'h20 + i), 2'(gp[i]), 0);
    cyc(1, 2'b00, 8'h00, 8'h00, 2'b10, 0);
    cyc(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    @(negedge cp);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
